// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall vectors, FSM encodings
// and register-address width. Pure declarations, no timing or flow control.
package stall_ctrl_pkg;

  localparam int RegAddrBus = 5;

  // Stall vector bit order: {WB, MEM, EX, ID, IF, PC}
  localparam logic [5:0] StallNone   = 6'b000000;
  localparam logic [5:0] StallFromId = 6'b000111;
  localparam logic [5:0] StallFromEx = 6'b001111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULTI = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic src_hit(
    input logic                  rd_en,
    input logic [RegAddrBus-1:0] rd_addr,
    input logic [RegAddrBus-1:0] wr_addr
  );
    return rd_en && (rd_addr == wr_addr);
  endfunction

endpackage

// File: rtl/stall_ctrl_multi_cycle_counter.sv
// Down-counter tracking remaining cycles of an EX multi-cycle op; is_one is combinational.
// Single-cycle load/decrement, no flow control (clear beats load beats decrement).
module multi_cycle_counter
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: stall_o is combinational from inputs and FSM state.
// No backpressure of its own; stall_o is the backpressure applied to the pipeline stages.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int STAT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_reg1_read_i,
  input  logic                  id_reg2_read_i,
  input  logic [RegAddrBus-1:0] id_reg1_addr_i,
  input  logic [RegAddrBus-1:0] id_reg2_addr_i,
  input  logic                  ex_wreg_i,
  input  logic [RegAddrBus-1:0] ex_wd_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_multi_start_i,
  input  logic [CNT_W-1:0]      ex_multi_cycles_i,
  input  logic                  flush_req_i,
  output logic [5:0]            stall_o,
  output logic                  flush_o,
  output logic                  busy_o,
  output logic [STAT_W-1:0]     stall_cnt_o
);

  state_e      state_q, state_d;
  logic        load_use;
  logic        multi_go;
  logic        cnt_clr, cnt_load, cnt_dec, cnt_is_one;
  logic [5:0]  stall_raw;
  logic        flush_raw;

  assign load_use = ex_wreg_i && ex_is_load_i && (ex_wd_i != '0) &&
                    (src_hit(id_reg1_read_i, id_reg1_addr_i, ex_wd_i) ||
                     src_hit(id_reg2_read_i, id_reg2_addr_i, ex_wd_i));

  assign multi_go = ex_multi_start_i && (ex_multi_cycles_i != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_raw = StallNone;
    flush_raw = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d = FLUSH;
          cnt_clr = 1'b1;
        end else if (multi_go) begin
          stall_raw = StallFromEx;
          // The start cycle is the first stall cycle, so MULTI covers N-1 more.
          if (ex_multi_cycles_i > CNT_W'(1)) begin
            state_d  = MULTI;
            cnt_load = 1'b1;
          end
        end else if (load_use) begin
          stall_raw = StallFromId;
        end
      end
      MULTI: begin
        if (flush_req_i) begin
          state_d = FLUSH;
          cnt_clr = 1'b1;
        end else begin
          stall_raw = StallFromEx;
          cnt_dec   = 1'b1;
          if (cnt_is_one) begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        flush_raw = 1'b1;
        if (flush_req_i) begin
          cnt_clr = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  multi_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_multi_cycle_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .load_val(ex_multi_cycles_i - CNT_W'(1)),
    .dec     (cnt_dec),
    .is_one  (cnt_is_one)
  );

  // Outputs are held quiet while reset is asserted, even with live hazard inputs.
  assign stall_o = rst ? stall_raw : StallNone;
  assign flush_o = rst && flush_raw;
  assign busy_o  = rst && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (stall_o[0] && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + STAT_W'(1);
    end
  end

endmodule
